// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared sprite geometry, colour and blink FSM definitions
package pong_pkg;

  localparam int SPR_W = 64;
  localparam int SPR_H = 32;
  localparam int COL_W = 6;
  localparam int ROW_W = 5;
  localparam int RGB_W = 12;

  localparam logic [RGB_W-1:0] TRANSPARENT = 12'h000;

  typedef enum logic [1:0] {
    ST_HIDDEN = 2'd0,
    ST_ON     = 2'd1,
    ST_OFF    = 2'd2
  } blink_state_t;

endpackage

// File: rtl/blink_ctrl.sv
// rtl/blink_ctrl.sv - frame-synchronous blink FSM and sprite position latches
module blink_ctrl #(
  parameter int BLINK_FRAMES = 30,
  parameter bit BLINK_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       show,
  input  logic [9:0] x0,
  input  logic [9:0] y0,
  output logic       visible,
  output logic [9:0] x_lat,
  output logic [9:0] y_lat
);
  import pong_pkg::*;

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  blink_state_t     state;
  logic [CNT_W-1:0] frame_cnt;

  // State, counter and position only move on frame_tick so a frame never tears
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HIDDEN;
      frame_cnt <= '0;
      visible   <= 1'b0;
      x_lat     <= '0;
      y_lat     <= '0;
    end else if (frame_tick) begin
      x_lat <= x0;
      y_lat <= y0;
      case (state)
        ST_HIDDEN: begin
          if (show) begin
            state     <= ST_ON;
            frame_cnt <= '0;
            visible   <= 1'b1;
          end
        end
        default: begin
          if (!show) begin
            state     <= ST_HIDDEN;
            frame_cnt <= '0;
            visible   <= 1'b0;
          end else if (!BLINK_EN) begin
            state     <= ST_ON;
            frame_cnt <= '0;
            visible   <= 1'b1;
          end else if (frame_cnt == CNT_LAST) begin
            frame_cnt <= '0;
            if (state == ST_ON) begin
              state   <= ST_OFF;
              visible <= 1'b0;
            end else begin
              state   <= ST_ON;
              visible <= 1'b1;
            end
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/prompt_sprite_overlay.sv
// rtl/prompt_sprite_overlay.sv - sprite hit test, ROM addressing and 2-clock merge pipeline
module prompt_sprite_overlay #(
  parameter int          SPR_W        = pong_pkg::SPR_W,
  parameter int          SPR_H        = pong_pkg::SPR_H,
  parameter logic [11:0] TRANSPARENT  = pong_pkg::TRANSPARENT,
  parameter int          BLINK_FRAMES = 30,
  parameter bit          BLINK_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        frame_tick,
  input  logic        show,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  input  logic [11:0] bg_rgb,
  output logic [4:0]  rom_row,
  output logic [5:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic [11:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        sprite_on
);
  import pong_pkg::*;

  logic       visible;
  logic [9:0] x_lat;
  logic [9:0] y_lat;

  blink_ctrl #(
    .BLINK_FRAMES (BLINK_FRAMES),
    .BLINK_EN     (BLINK_EN)
  ) u_blink_ctrl (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .show       (show),
    .x0         (x0),
    .y0         (y0),
    .visible    (visible),
    .x_lat      (x_lat),
    .y_lat      (y_lat)
  );

  // 11-bit compares: a sprite running past 1023 clips instead of wrapping to x/y 0
  logic [10:0] x_lo, y_lo, x_hi, y_hi, x_pos, y_pos;
  logic        hit;

  assign x_pos = {1'b0, pixel_x};
  assign y_pos = {1'b0, pixel_y};
  assign x_lo  = {1'b0, x_lat};
  assign y_lo  = {1'b0, y_lat};
  assign x_hi  = x_lo + 11'(SPR_W);
  assign y_hi  = y_lo + 11'(SPR_H);
  assign hit   = (x_pos >= x_lo) && (x_pos < x_hi) && (y_pos >= y_lo) && (y_pos < y_hi);

  assign rom_col = hit ? COL_W'(pixel_x - x_lat) : '0;
  assign rom_row = hit ? ROW_W'(pixel_y - y_lat) : '0;

  logic        hit_d1, visible_d1, video_on_d1, hsync_d1, vsync_d1;
  logic [11:0] bg_d1;
  logic        opaque;

  assign opaque = hit_d1 && visible_d1 && video_on_d1 && (rom_data != TRANSPARENT);

  // Stage 1: hold pixel context for the clock the ROM spends returning data
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_d1      <= 1'b0;
      visible_d1  <= 1'b0;
      video_on_d1 <= 1'b0;
      hsync_d1    <= 1'b0;
      vsync_d1    <= 1'b0;
      bg_d1       <= '0;
    end else begin
      hit_d1      <= hit;
      visible_d1  <= visible;
      video_on_d1 <= video_on;
      hsync_d1    <= hsync_in;
      vsync_d1    <= vsync_in;
      bg_d1       <= bg_rgb;
    end
  end

  // Stage 2: merge sprite over background and keep syncs aligned with colour
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out   <= '0;
      sprite_on <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      sprite_on <= opaque;
      hsync_out <= hsync_d1;
      vsync_out <= vsync_d1;
      if (opaque)
        rgb_out <= rom_data;
      else if (video_on_d1)
        rgb_out <= bg_d1;
      else
        rgb_out <= '0;
    end
  end

endmodule

// File: tb/tb_prompt_sprite_overlay.sv
// tb/tb_prompt_sprite_overlay.sv - scoreboard bench for the prompt sprite overlay
module tb_prompt_sprite_overlay;

  localparam logic [11:0] BG  = 12'h5A3;
  localparam logic [11:0] BG2 = 12'h0F0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        video_on = 1'b1, hsync_in = 1'b1, vsync_in = 1'b1;
  logic        frame_tick = 1'b0, show = 1'b0;
  logic [9:0]  x0 = 10'd100, y0 = 10'd50;
  logic [11:0] bg_rgb = BG;
  logic [4:0]  rom_row;
  logic [5:0]  rom_col;
  logic [11:0] rom_data = '0;
  logic [11:0] rgb_out;
  logic        hsync_out, vsync_out, sprite_on;

  prompt_sprite_overlay #(
    .BLINK_FRAMES (2),
    .BLINK_EN     (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .frame_tick (frame_tick),
    .show       (show),
    .x0         (x0),
    .y0         (y0),
    .bg_rgb     (bg_rgb),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_data   (rom_data),
    .rgb_out    (rgb_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .sprite_on  (sprite_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] rom_fn(input logic [4:0] r, input logic [5:0] c);
    if (c[1:0] == 2'b11) return 12'h000;
    if (r == 5'd0 && c == 6'd0) return 12'hCF7;
    return {1'b1, r, c};
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_row, rom_col);

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        on;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        chk("sb_late", 32'(cyc), 32'(e.due));
      end else begin
        chk("rgb_out", 32'(rgb_out), 32'(e.rgb));
        chk("sprite_on", 32'(sprite_on), 32'(e.on));
        chk("hsync_out", 32'(hsync_out), 32'(e.hs));
        chk("vsync_out", 32'(vsync_out), 32'(e.vs));
      end
    end
  end

  task automatic px(input logic [9:0] x, input logic [9:0] y, input logic von,
                    input logic hs, input logic vs, input logic tk, input logic [11:0] bg,
                    input logic [11:0] e_rgb, input logic e_on,
                    input logic [4:0] e_row, input logic [5:0] e_col);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    pixel_x    = x;
    pixel_y    = y;
    video_on   = von;
    hsync_in   = hs;
    vsync_in   = vs;
    frame_tick = tk;
    bg_rgb     = bg;
    e.due = cyc + 2;
    e.rgb = e_rgb;
    e.on  = e_on;
    e.hs  = hs;
    e.vs  = vs;
    sb.push_back(e);
    #1;
    chk("rom_row", 32'(rom_row), 32'(e_row));
    chk("rom_col", 32'(rom_col), 32'(e_col));
  endtask

  task automatic tick();
    px(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, BG, 12'h000, 1'b0, 5'd0, 6'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      video_on   = 1'b0;
      hsync_in   = 1'b0;
      vsync_in   = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rgb"}, 32'(rgb_out), 32'h0);
    chk({tag, "_on"}, 32'(sprite_on), 32'h0);
    chk({tag, "_hs"}, 32'(hsync_out), 32'h0);
    chk({tag, "_vs"}, 32'(vsync_out), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");

    show = 1'b1;
    px(100, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    px(100, 50, 1, 1, 0, 1, BG, BG, 0, 0, 0);
    px(100, 50, 1, 0, 1, 0, BG, 12'hCF7, 1, 0, 0);
    px(101, 50, 1, 1, 1, 0, BG, 12'h801, 1, 0, 1);
    px(103, 50, 1, 0, 0, 0, BG, BG, 0, 0, 3);
    px(164, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    px(162, 81, 1, 0, 0, 0, BG2, 12'hFFE, 1, 31, 62);
    px(100, 82, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    px(100, 50, 0, 1, 1, 0, BG, 12'h000, 0, 0, 0);

    tick();
    px(100, 50, 1, 0, 0, 0, BG, 12'hCF7, 1, 0, 0);
    tick();
    px(100, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    px(101, 50, 1, 0, 0, 0, BG, BG, 0, 0, 1);
    tick();
    px(100, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    x0 = 10'd200;
    px(100, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    tick();
    px(100, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    px(200, 50, 1, 0, 0, 0, BG, 12'hCF7, 1, 0, 0);
    x0 = 10'd300;
    px(200, 50, 1, 0, 0, 0, BG, 12'hCF7, 1, 0, 0);
    show = 1'b0;
    px(201, 50, 1, 0, 0, 0, BG, 12'h801, 1, 0, 1);
    tick();
    px(300, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    px(200, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);

    x0 = 10'd1000;
    show = 1'b1;
    tick();
    px(1000, 50, 1, 0, 0, 0, BG, 12'hCF7, 1, 0, 0);
    px(1022, 50, 1, 0, 0, 0, BG, 12'h816, 1, 0, 22);
    px(1023, 50, 1, 0, 0, 0, BG, BG, 0, 0, 23);
    px(0, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    px(39, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    tick();
    px(1000, 50, 1, 0, 0, 0, BG, 12'hCF7, 1, 0, 0);
    tick();
    px(1000, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    tick();
    px(1000, 50, 1, 0, 0, 0, BG, BG, 0, 0, 0);
    tick();
    px(1000, 50, 1, 1, 1, 0, BG, 12'hCF7, 1, 0, 0);

    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_zero("rst_mid");

    px(1000, 50, 1, 1, 0, 0, BG, BG, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk_zero("rst_rel");
    px(1000, 50, 1, 0, 1, 0, BG, BG, 0, 0, 0);
    tick();
    px(1000, 50, 1, 0, 0, 0, BG, 12'hCF7, 1, 0, 0);

    idle(1);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prompt_sprite_overlay.md
# prompt_sprite_overlay

Pixel-pipeline stage sitting directly upstream of the 64×32 prompt-sprite ROM and directly downstream of the VGA sync generator. It converts the current scan position into ROM row/column addresses and absorbs the ROM's one-clock registered-address latency. It merges the returned sprite colour over the game background, keyed on a transparent colour. A frame-synchronous blink state machine shows or hides the prompt and latches its screen position only at frame start, so a frame never tears.

## Interface
- `SPR_W`, 64: sprite width in pixels; must equal 2^(`rom_col` width).
- `SPR_H`, 32: sprite height in pixels; must equal 2^(`rom_row` width).
- `TRANSPARENT`, 12'h000: ROM colour treated as see-through.
- `BLINK_FRAMES`, 30: frames per blink half-period; ≥1.
- `BLINK_EN`, 1: 1 = blink while shown, 0 = steady on.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-high.
- `pixel_x` in 10: current scan column.
- `pixel_y` in 10: current scan row.
- `video_on` in 1: active display region.
- `hsync_in` in 1: horizontal sync from the sync generator.
- `vsync_in` in 1: vertical sync from the sync generator.
- `frame_tick` in 1: one-clock pulse at frame start.
- `show` in 1: request the prompt to be displayed.
- `x0` in 10: sprite top-left corner, x coordinate.
- `y0` in 10: sprite top-left corner, y coordinate.
- `bg_rgb` in 12: background colour for the current pixel.
- `rom_row` out 5: sprite ROM row address.
- `rom_col` out 6: sprite ROM column address.
- `rom_data` in 12: ROM colour; valid one clock after the address.
- `rgb_out` out 12: merged pixel colour.
- `hsync_out` out 1: `hsync_in` delayed to match `rgb_out`.
- `vsync_out` out 1: `vsync_in` delayed to match `rgb_out`.
- `sprite_on` out 1: opaque sprite pixel currently being driven.

## Operation
- **Latches:** `x_lat`/`y_lat` load `x0`/`y0` only on `frame_tick`. Reset clears both to 0.
- **Hit test (stage 0, combinational):**
  - Use 11-bit compares so there is no wrap-around: `pixel_x` ≥ `x_lat` and `pixel_x` < `x_lat`+`SPR_W`, and likewise for y with `SPR_H`.
  - A sprite running past 1023 is simply clipped.
- **Address:**
  - `rom_col` = (`pixel_x`−`x_lat`)[5:0] and `rom_row` = (`pixel_y`−`y_lat`)[4:0] on a hit.
  - Both are 0 when there is no hit.
- **FSM** (states HIDDEN, ON, OFF; reset → HIDDEN, counter 0). All transitions happen only on `frame_tick`:
  - HIDDEN: if `show` → ON, counter cleared.
  - ON/OFF: if `show`=0 → HIDDEN, counter cleared.
  - ON/OFF with `BLINK_EN`=1 and counter = `BLINK_FRAMES`−1 → toggle ON↔OFF and clear counter; otherwise counter+1.
  - `BLINK_EN`=0: stay in ON, counter held at 0.
- **`visible`:** asserted only in state ON. It is sampled into the pipeline alongside the hit flag.
- **Merge (stage 1):** opaque = `hit_d1` & `visible_d1` & `video_on_d1` & (`rom_data` ≠ `TRANSPARENT`).
  - If opaque: `rgb_out` ← `rom_data`.
  - Else if `video_on_d1`: `rgb_out` ← `bg_d1`.
  - Else: `rgb_out` ← 0.
- **`sprite_on`:** registered copy of the opaque flag.

## Timing
- **Pipeline:**
  - Stage 0 = cycle N: inputs applied, address driven.
  - Stage 1 = cycle N+1: `rom_data` valid; hit, visible, `video_on`, `bg_rgb`, hsync and vsync are registered to the `_d1` copies.
  - Stage 2 = cycle N+2: `rgb_out`, `sprite_on`, `hsync_out`, `vsync_out` registered.
- **Latency:** exactly 2 clocks for every output relative to its inputs. All outputs stay mutually aligned.
- **Throughput:** one pixel per clock. No stalls and no handshake; the block runs freely on every clock.
- **Reset values:** `rgb_out`=0, `sprite_on`=0, `hsync_out`=0, `vsync_out`=0; every pipeline register = 0; `x_lat`=`y_lat`=0; FSM = HIDDEN.
  - The first valid outputs appear 2 clocks after `reset` deasserts.
- **Reset mid-frame:** `reset` blanks the output immediately on the next clock. The sprite stays hidden until the first `frame_tick` with `show`=1.
- **Same-clock events:** `frame_tick` coinciding with a hit pixel uses the pre-update latch and state for that pixel; new values apply from the next clock.
- **Changes between ticks:** changes to `show`, `x0` or `y0` between ticks have no visible effect until the next `frame_tick`.

## Structure
- **Shared package (`pong_pkg`):** `SPR_W`/`SPR_H` constants, the 12-bit colour width, the `TRANSPARENT` colour, and the blink FSM state encoding.
- **Sub-module:** `blink_ctrl`, which holds the FSM, frame counter and position latches and outputs `visible`, `x_lat` and `y_lat`.
- **Top level:** hit test, address generation and the two-stage delay pipeline. The ROM is instantiated outside this block, by the parent.

## Test plan
- **Single opaque pixel:** ROM model; `x0`=100, `y0`=50, `show`=1, then `frame_tick`; drive `pixel_x`=100, `pixel_y`=50 → `rom_row`=0, `rom_col`=0 the same cycle; 2 clocks later `rgb_out`=12'hCF7 and `sprite_on`=1.
- **Transparent and outside pixels:** a transparent pixel at `pixel_x`=103, `pixel_y`=50 (ROM returns 0) → `rgb_out`=`bg_rgb` at N+2. `pixel_x`=164 (outside) → `rom_col`=0, `rgb_out`=`bg_rgb`.
- **Blink:** `BLINK_FRAMES`=2 with 10 `frame_tick`s → ON for 2 frames, OFF for 2, and so on. During OFF, `sprite_on` is never asserted.
- **Frame-synchronous changes:** `x0` changed mid-frame → the output is unchanged until the next `frame_tick`. `show`=0 mid-frame → the sprite stays visible until the tick, then goes HIDDEN.
- **Right-edge clipping:** `x0`=1000 → pixels 1000–1023 hit; no wrap to x 0–39.
- **Reset alignment:** assert `reset` mid-sprite → every output is 0 on the next clock, and hsync/vsync delay alignment is verified at 2 clocks after release.
